instr_prefetch_buffer: RTL

INSTR_PREFETCH_BUFFER -- requirements
Module: instr_prefetch_buffer

---
 rtl/proc_defs_pkg.sv | 17 +
 rtl/prefetch_fifo.sv | 51 +++++
 rtl/instr_prefetch_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/proc_defs_pkg.sv
// Shared processor-front-end definitions: prefetch FSM encodings, NOP word,
// PC step and the FIFO entry layout.
package proc_defs_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; head is read
// combinationally from the storage array.
module prefetch_fifo
   import proc_defs_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_entry_t             din_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (!rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage carries no reset; occupancy alone qualifies the head.
   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer in front of a synchronous ROM with redirect flush.
// Optional PREFETCH_MISALIGN_TRAP_EN traps misaligned redirects into HALT.
module instr_prefetch_buffer
   import proc_defs_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 9,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDR_W-1:0]        rom_addr,
   input  logic [31:0]              rom_dout,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     instr_valid,
   output logic [31:0]              instr,
   output logic [31:0]              instr_pc,
   input  logic                     instr_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     misalign_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [1:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   inflight_pc_q;
   logic          inflight_q;
   fetch_entry_t  last_q;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic [CW-1:0] fifo_count;
   logic          issue_c;
   logic          push_c;
   logic          pop_c;
   logic          room_c;
   logic [31:0]   target_c;

`ifdef PREFETCH_MISALIGN_TRAP_EN
   logic err_q, err_d;
   logic mis_c;

   assign target_c     = redirect_pc;
   assign mis_c        = |redirect_pc[1:0];
   assign misalign_err = err_q;
`else
   assign target_c     = redirect_pc & ~32'h3;
   assign misalign_err = 1'b0;
`endif

   // An issued fetch returns next cycle, so it must be reserved a slot now.
   assign room_c = (fifo_count + CW'(inflight_q)) < CW'(DEPTH);
   assign push_c = inflight_q && !redirect;
   assign pop_c  = instr_valid && instr_ready;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      issue_c    = 1'b0;
`ifdef PREFETCH_MISALIGN_TRAP_EN
      err_d      = err_q;
`endif
      case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN:  issue_c = !redirect && room_c;
         default: ;
      endcase
      if (redirect) begin
         fetch_pc_d = target_c;
`ifdef PREFETCH_MISALIGN_TRAP_EN
         if (mis_c) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
         end else begin
            state_d = ST_RUN;
            err_d   = 1'b0;
         end
`else
         state_d = ST_RUN;
`endif
      end else if (issue_c) begin
         fetch_pc_d = fetch_pc_q + PC_INC;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         last_q        <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= issue_c;
         inflight_pc_q <= fetch_pc_q;
         if (instr_valid) last_q <= head;
      end
   end

`ifdef PREFETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end
`endif

   assign push_entry.pc    = inflight_pc_q;
   assign push_entry.instr = rom_dout;

   prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .din_i   (push_entry),
      .pop_i   (pop_c),
      .flush_i (redirect),
      .head_o  (head),
      .count_o (fifo_count)
   );

   // Outputs hold the last presented entry while the buffer is empty.
   assign rom_addr    = fetch_pc_q[ADDR_W-1:0];
   assign instr_valid = (fifo_count != '0);
   assign instr       = instr_valid ? head.instr : last_q.instr;
   assign instr_pc    = instr_valid ? head.pc    : last_q.pc;
   assign count       = fifo_count;

endmodule
